// File: rtl/fetch_unit.sv
// Instruction-fetch stage: generates the sequential/redirected fetch address
// stream, tracks outstanding memory requests with a credit scheme, drops
// responses that belong to a flushed path, and buffers {pc, instr} pairs for decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
    localparam int CW = PW + 1;                           // counter width (holds DEPTH)

    // Architectural state
    logic [31:0]   fetch_pc_reg;
    logic [CW-1:0] pend_reg;       // accepted requests not yet answered
    logic [CW-1:0] drop_cnt_reg;   // outstanding responses belonging to a flushed path
    logic [CW-1:0] count_reg;      // entries held in the output queue

    // Tag FIFO: PC of each outstanding request, in request order
    logic [31:0]   tag_mem [DEPTH];
    logic [PW-1:0] tag_wptr_reg;
    logic [PW-1:0] tag_rptr_reg;

    // Output FIFO feeding decode
    logic [31:0]   out_pc_mem    [DEPTH];
    logic [31:0]   out_instr_mem [DEPTH];
    logic [PW-1:0] out_wptr_reg;
    logic [PW-1:0] out_rptr_reg;

    // Handshake / event decode
    logic [CW:0]   credits_used;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          rsp_stale;
    logic          pop_fire;

    // Credits cover both in-flight requests and buffered instructions, so a
    // response can always be accepted without backpressure.
    assign credits_used   = {1'b0, pend_reg} + {1'b0, count_reg};
    assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign fetch_pc       = fetch_pc_reg;

    assign req_fire  = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire  = imem_rsp_valid && (pend_reg != '0);
    assign rsp_keep  = rsp_fire && !redirect_valid && (drop_cnt_reg == '0);
    assign rsp_stale = rsp_fire && !redirect_valid && (drop_cnt_reg != '0);

    // Head of the output queue; zero when empty so idle outputs are clean.
    assign if_valid = (count_reg != '0) && !redirect_valid;
    assign if_pc    = (count_reg != '0) ? out_pc_mem[out_rptr_reg]    : 32'h0;
    assign if_instr = (count_reg != '0) ? out_instr_mem[out_rptr_reg] : 32'h0;
    assign pop_fire = if_valid && if_ready;

    // Fetch address, credit counters and FIFO pointers; redirect overrides all
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            pend_reg     <= '0;
            drop_cnt_reg <= '0;
            count_reg    <= '0;
            tag_wptr_reg <= '0;
            tag_rptr_reg <= '0;
            out_wptr_reg <= '0;
            out_rptr_reg <= '0;
        end else begin
            // The pending count and tag pops follow the memory regardless of
            // redirects, since every issued request still gets one response.
            pend_reg     <= pend_reg + CW'(req_fire) - CW'(rsp_fire);
            tag_wptr_reg <= tag_wptr_reg + PW'(req_fire);
            tag_rptr_reg <= tag_rptr_reg + PW'(rsp_fire);

            if (redirect_valid) begin
                fetch_pc_reg <= redirect_pc;
                // Everything still in flight (minus this cycle's arrival) is stale.
                drop_cnt_reg <= pend_reg - CW'(rsp_fire);
                count_reg    <= '0;
                out_wptr_reg <= '0;
                out_rptr_reg <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (rsp_stale) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                end
                count_reg    <= count_reg + CW'(rsp_keep) - CW'(pop_fire);
                out_wptr_reg <= out_wptr_reg + PW'(rsp_keep);
                out_rptr_reg <= out_rptr_reg + PW'(pop_fire);
            end
        end
    end

    // FIFO storage writes; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wptr_reg] <= fetch_pc_reg;
        end
        if (rsp_keep) begin
            out_pc_mem[out_wptr_reg]    <= tag_mem[tag_rptr_reg];
            out_instr_mem[out_wptr_reg] <= imem_rsp_data;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program-counter register.
- Owns the fetch address sequence: RESET_PC, then +4, or a redirect target.
- Issues requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers {pc, instr} pairs in a DEPTH-entry queue that feeds decode over a valid/ready interface, and discards stale responses after a branch/jump redirect.

Parameters:
DEPTH, 4, total credits: in-flight requests plus buffered instructions; power of 2, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears all state on the next posedge
redirect_valid  input  1  branch/jump taken; flush and restart fetch
redirect_pc  input  32  new fetch address, sampled when redirect_valid=1
imem_req_valid  output  1  request present
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  fetch address (= fetch_pc)
imem_rsp_valid  input  1  response data valid; responses return in request order
imem_rsp_data  input  32  instruction word
if_valid  output  1  head instruction valid to decode
if_ready  input  1  decode consumes head
if_pc  output  32  PC of head instruction
if_instr  output  32  head instruction word
fetch_pc  output  32  current fetch address register, for debug/trace

Behaviour:
Reset:
- Synchronous, active-high. Required state after reset: fetch_pc=RESET_PC, pend=0, drop_cnt=0, queue empty.
- Outputs after reset: if_valid=0, if_pc=0, if_instr=0.
- While reset=1, imem_req_valid=0. All other inputs are ignored.
- Reset mid-operation discards everything. Any responses still in flight after reset are the memory's responsibility; the bench does not deliver them.

Internal state:
- fetch_pc.
- pend: count of accepted requests not yet answered, width clog2(DEPTH)+1.
- drop_cnt: count of stale responses still to discard, drop_cnt <= pend.
- tag FIFO: PCs of outstanding requests, DEPTH entries.
- out FIFO: {pc, instr} entries, DEPTH entries, with count.

Request channel:
- imem_req_valid = !reset && !redirect_valid && (pend + count < DEPTH). This is combinational from registered state plus redirect_valid.
- imem_req_addr = fetch_pc.
- Handshake on valid && ready: fetch_pc <= fetch_pc + 4 (wraps modulo 2^32), pend increments, fetch_pc is pushed into the tag FIFO.
- Withdrawing valid without acceptance is legal; memory samples only on valid && ready.

Response channel:
- No backpressure on responses. Credits guarantee space.
- When imem_rsp_valid=1 and drop_cnt>0: discard, drop_cnt decrements, tag FIFO pops, pend decrements.
- When imem_rsp_valid=1 and drop_cnt=0: pop tag to get pc, push {pc, imem_rsp_data} into out FIFO, pend decrements.
- Latency: response at cycle N makes the instruction visible on if_* at cycle N+1 if the queue was empty. There is no combinational bypass.
- imem_rsp_valid with pend=0 is a protocol error. Ignore it; the bench asserts it never occurs.

Decode interface:
- if_valid = (count > 0) && !redirect_valid.
- if_pc and if_instr come from the head entry; they hold 0 when empty.
- Pop on if_valid && if_ready. Head is stable while if_valid=1 and if_ready=0.
- Push and pop in the same cycle are allowed; count is unchanged.

Redirect (takes priority over every other event in that cycle):
- fetch_pc <= redirect_pc.
- out FIFO cleared; no pop occurs that cycle.
- No request is issued that cycle.
- A response arriving that cycle is discarded.
- pend updates as normal for the response.
- drop_cnt <= pend minus the response arriving this cycle (0 or 1). The tag FIFO keeps entries so stale responses can still pop tags.
- Back-to-back redirects: each one reloads fetch_pc; drop_cnt keeps tracking all outstanding responses.
- First request to redirect_pc is issued on the cycle after the redirect.

Boundary conditions:
- pend + count = DEPTH: imem_req_valid=0 until a pop or a discarded response frees a credit.
- fetch_pc = 32'hFFFF_FFFC wraps to 0 after acceptance.

Test Plan:
1. Reset, then imem_req_ready=1 constantly, rsp one cycle after each request, if_ready=1 -> addresses 0,4,8,C issued; decode sees pc 0,4,8,C in order, one per cycle after initial latency.
2. Fill: if_ready=0, memory always ready and responding -> exactly DEPTH=4 requests issued, then imem_req_valid=0. Release if_ready -> requests resume one cycle after the first pop.
3. Redirect with 2 outstanding requests (pc 8, C) and 1 buffered (pc 4), redirect_pc=32'h100 -> if_valid=0 next cycle; both late responses are dropped; next decode output is pc 100 with its instruction.
4. Redirect in the same cycle as a response and if_ready=1 -> response dropped, no pop counted, drop_cnt=pend-1, no request that cycle; 32'h200 requested next cycle.
5. imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_req_addr stable throughout; fetch_pc does not advance.
6. Synchronous reset asserted mid-stream with 3 entries buffered -> next cycle if_valid=0, fetch_pc=0, imem_req_valid=0 while reset=1; a request to 0 follows the first cycle after deassertion.
